dwc_wlast_regen: RTL
====================

Name: dwc_wlast_regen

Overview:
- Stage directly downstream of the down-converter's slave-side AW/W outputs, in front of the narrow slave port.
- Captures each issued AWLEN into a small length FIFO and re-times the W channel through a 2-entry skid buffer.
- Regenerates SLAVE_WLAST from a beat counter, so the slave always sees burst framing consistent with the AW it accepted.
- Other AW fields bypass this block at the top level; only AWVALID/AWREADY/AWLEN are routed through it.

Parameters:
- DATA_WIDTH, 32, W data width (narrow side).
- STRB_WIDTH, 4, DATA_WIDTH/8.
- USER_WIDTH, 1, WUSER width.
- LEN_FIFO_DEPTH, 4, length FIFO entries; power of two, >=2.

Ports:
- ACLK  in  1  clock.
- sysReset  in  1  asynchronous active-high reset.
- MASTER_AWVALID  in  1  AW valid from converter.
- MASTER_AWREADY  out  1  AW ready to converter.
- MASTER_AWLEN  in  8  AW burst length-1.
- SLAVE_AWVALID  out  1  AW valid to slave.
- SLAVE_AWREADY  in  1  AW ready from slave.
- MASTER_WDATA  in  DATA_WIDTH  W data in.
- MASTER_WSTRB  in  STRB_WIDTH  W strobes in.
- MASTER_WUSER  in  USER_WIDTH  W user in.
- MASTER_WLAST  in  1  W last in (used only by the check feature).
- MASTER_WVALID  in  1  W valid in.
- MASTER_WREADY  out  1  W ready out, registered.
- SLAVE_WDATA  out  DATA_WIDTH  W data out.
- SLAVE_WSTRB  out  STRB_WIDTH  W strobes out.
- SLAVE_WUSER  out  USER_WIDTH  W user out.
- SLAVE_WLAST  out  1  regenerated last.
- SLAVE_WVALID  out  1  W valid out.
- SLAVE_WREADY  in  1  W ready from slave.
- WLAST_ERR  out  1  sticky framing-mismatch flag.

Behaviour:
- Single clock ACLK; sysReset is asynchronous and active-high.
- Reset (async, any cycle, including mid-burst):
  - FIFO pointers, count, beat counter and both skid entries clear; WLAST_ERR=0.
  - SLAVE_WVALID=0, SLAVE_WLAST=0, data/strb/user outputs=0, MASTER_WREADY=0.
  - MASTER_WREADY rises 1 on the first ACLK edge after reset deasserts.
  - In-flight bursts are discarded.
- AW path (combinational):
  - SLAVE_AWVALID = MASTER_AWVALID & !lenFull.
  - MASTER_AWREADY = SLAVE_AWREADY & !lenFull.
  - Push AWLEN on SLAVE_AWVALID & SLAVE_AWREADY.
  - Full blocks AW even when a pop occurs in the same cycle.
- Length FIFO:
  - Pointers are log2(LEN_FIFO_DEPTH) bits and wrap naturally; count is log2+1 bits.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- W skid buffer:
  - Entries are main (drives outputs) and skid.
  - MASTER_WREADY = !skidValid, registered.
  - An input beat is accepted on MASTER_WVALID & MASTER_WREADY. It loads main if main is empty or main drains this cycle; otherwise it loads skid.
  - When main drains, skid moves to main.
  - Latency: input to SLAVE_WVALID = 1 cycle.
  - Sustained throughput: 1 beat/cycle.
  - W beats may arrive before their AW; the buffer fills and then backpressures.
- Output gating:
  - SLAVE_WVALID = mainValid & !lenEmpty.
  - Once SLAVE_WVALID is high, it and the payload stay stable until SLAVE_WREADY.
- Beat counter (8 bits):
  - SLAVE_WLAST = SLAVE_WVALID & (beatCnt == lenHead).
  - On an output handshake without last: beatCnt+1.
  - On an output handshake with last: beatCnt=0 and FIFO pop.
  - AWLEN=0 gives a single-beat burst with WLAST on beat 0.
  - AWLEN=255 gives 256 beats; the counter never wraps.

Optional Feature:
- Macro: DWC_WLAST_CHECK_EN.
- Defined:
  - Each skid entry also stores MASTER_WLAST.
  - On an output handshake, stored last != regenerated last sets WLAST_ERR=1, sticky until reset.
  - Output framing always follows the regenerated value.
- Undefined:
  - Stored-last bits are not built.
  - WLAST_ERR is tied 0.
  - MASTER_WLAST is unused.

Decomposition:
- Shared package holds:
  - the W payload struct (data, strb, user, optional last);
  - the LEN_W=8 constant;
  - the FIFO pointer-width function clog2.
- One natural sub-module: dwc_len_fifo (push/pop/full/empty/head, parameterised depth and width).

Test Plan:
- AWLEN=3 then 4 beats, slave always ready -> SLAVE_WLAST only on beat 3; FIFO empty afterwards; 1-cycle latency.
- 4 beats presented before AW, then AWLEN=3 -> SLAVE_WVALID=0 until the AW handshake; MASTER_WREADY drops after 2 beats are buffered; all 4 beats delivered in order.
- AWLEN=0 x LEN_FIFO_DEPTH+1 with W held off -> the (depth+1)th AW stalls (MASTER_AWREADY=0) until the first W beat completes.
- SLAVE_WREADY toggling 1010... over AWLEN=7 with continuous input -> no beat lost or duplicated, payload stable while stalled.
- With DWC_WLAST_CHECK_EN: AWLEN=1, input WLAST on beat 0 -> WLAST_ERR=1 at beat 0 handshake, held until sysReset.
- sysReset pulsed mid-burst (beat 2 of AWLEN=5) -> all valids 0 immediately; after release, a fresh AWLEN=1 burst frames correctly.

Source files
------------

// File: rtl/dwc_wlast_regen_pkg.sv
// Shared types and helpers for the WLAST regeneration stage.
// The W payload carries a stored-last bit only when DWC_WLAST_CHECK_EN is defined.
package dwc_wlast_regen_pkg;

  localparam int LEN_W    = 8;
  localparam int W_DATA_W = 32;
  localparam int W_STRB_W = W_DATA_W / 8;
  localparam int W_USER_W = 1;

  typedef struct packed {
    logic [W_DATA_W-1:0] data;
    logic [W_STRB_W-1:0] strb;
    logic [W_USER_W-1:0] user;
`ifdef DWC_WLAST_CHECK_EN
    logic                last;
`endif
  } w_beat_t;

  // Ceiling log2, used to size FIFO pointers (value >= 2 expected).
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dwc_len_fifo.sv
// Small burst-length FIFO; head is read combinationally so the beat counter
// can compare against it in the same cycle the entry becomes visible.
module dwc_len_fifo
  import dwc_wlast_regen_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
  end

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/dwc_wlast_regen.sv
// Re-times the narrow W channel through a 2-entry skid buffer and regenerates
// SLAVE_WLAST from accepted AWLEN values. Optional check: DWC_WLAST_CHECK_EN.
module dwc_wlast_regen
  import dwc_wlast_regen_pkg::*;
#(
  parameter int DATA_WIDTH     = W_DATA_W,
  parameter int STRB_WIDTH     = W_STRB_W,
  parameter int USER_WIDTH     = W_USER_W,
  parameter int LEN_FIFO_DEPTH = 4
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  input  logic                  MASTER_AWVALID,
  output logic                  MASTER_AWREADY,
  input  logic [LEN_W-1:0]      MASTER_AWLEN,
  output logic                  SLAVE_AWVALID,
  input  logic                  SLAVE_AWREADY,
  input  logic [DATA_WIDTH-1:0] MASTER_WDATA,
  input  logic [STRB_WIDTH-1:0] MASTER_WSTRB,
  input  logic [USER_WIDTH-1:0] MASTER_WUSER,
  input  logic                  MASTER_WLAST,
  input  logic                  MASTER_WVALID,
  output logic                  MASTER_WREADY,
  output logic [DATA_WIDTH-1:0] SLAVE_WDATA,
  output logic [STRB_WIDTH-1:0] SLAVE_WSTRB,
  output logic [USER_WIDTH-1:0] SLAVE_WUSER,
  output logic                  SLAVE_WLAST,
  output logic                  SLAVE_WVALID,
  input  logic                  SLAVE_WREADY,
  output logic                  WLAST_ERR
);

  logic             len_full;
  logic             len_empty;
  logic             len_push;
  logic             len_pop;
  logic [LEN_W-1:0] len_head;

  // AW is blocked on full regardless of a same-cycle pop to keep the path short.
  assign SLAVE_AWVALID  = MASTER_AWVALID & ~len_full;
  assign MASTER_AWREADY = SLAVE_AWREADY & ~len_full;
  assign len_push       = SLAVE_AWVALID & SLAVE_AWREADY;

  dwc_len_fifo #(
    .DEPTH (LEN_FIFO_DEPTH),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk   (ACLK),
    .rst   (sysReset),
    .push  (len_push),
    .pop   (len_pop),
    .din   (MASTER_AWLEN),
    .full  (len_full),
    .empty (len_empty),
    .head  (len_head)
  );

  w_beat_t          main_reg, main_next;
  w_beat_t          skid_reg, skid_next;
  logic             main_valid_reg, main_valid_next;
  logic             skid_valid_reg, skid_valid_next;
  logic             wready_reg;
  logic [LEN_W-1:0] beat_cnt_reg;
  w_beat_t          in_beat;
  logic             w_accept;
  logic             w_drain;
  logic             out_valid;
  logic             out_last;

  always_comb begin
    in_beat      = '0;
    in_beat.data = MASTER_WDATA;
    in_beat.strb = MASTER_WSTRB;
    in_beat.user = MASTER_WUSER;
`ifdef DWC_WLAST_CHECK_EN
    in_beat.last = MASTER_WLAST;
`endif
  end

  assign w_accept  = MASTER_WVALID & wready_reg;
  assign out_valid = main_valid_reg & ~len_empty;
  assign out_last  = out_valid & (beat_cnt_reg == len_head);
  assign w_drain   = out_valid & SLAVE_WREADY;
  assign len_pop   = w_drain & out_last;

  // wready is the registered inverse of skid occupancy, so an accept never
  // coincides with a full skid entry.
  always_comb begin
    main_next       = main_reg;
    main_valid_next = main_valid_reg;
    skid_next       = skid_reg;
    skid_valid_next = skid_valid_reg;
    if (w_drain && skid_valid_reg) begin
      main_next       = skid_reg;
      skid_valid_next = 1'b0;
    end else if (w_drain || !main_valid_reg) begin
      main_valid_next = w_accept;
      if (w_accept) main_next = in_beat;
    end else if (w_accept) begin
      skid_next       = in_beat;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge sysReset) begin
    if (sysReset) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      wready_reg     <= 1'b0;
      beat_cnt_reg   <= '0;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      wready_reg     <= ~skid_valid_next;
      if (w_drain) beat_cnt_reg <= out_last ? '0 : beat_cnt_reg + LEN_W'(1);
    end
  end

`ifdef DWC_WLAST_CHECK_EN
  logic err_reg;

  always_ff @(posedge ACLK or posedge sysReset) begin
    if (sysReset) begin
      err_reg <= 1'b0;
    end else if (w_drain && (main_reg.last != out_last)) begin
      err_reg <= 1'b1;
    end
  end

  assign WLAST_ERR = err_reg;
`else
  logic unused_wlast;
  assign unused_wlast = MASTER_WLAST;
  assign WLAST_ERR    = 1'b0;
`endif

  assign MASTER_WREADY = wready_reg;
  assign SLAVE_WVALID  = out_valid;
  assign SLAVE_WLAST   = out_last;
  assign SLAVE_WDATA   = main_reg.data;
  assign SLAVE_WSTRB   = main_reg.strb;
  assign SLAVE_WUSER   = main_reg.user;

endmodule
